// File: rtl/led_sequencer.sv
// led_sequencer: multi-mode LED pattern generator that owns the step-delay register.
// Define LED_SEQ_SYNC_EN to treat pause/restart/faster/slower as async levels (sync + edge detect).
module led_sequencer #(
  parameter int N_LEDS     = 10,
  parameter int DELAY_W    = 4,
  parameter int DELAY_INIT = 7,
  parameter int PRESCALE   = 2500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pause,
  input  logic               restart,
  input  logic               faster,
  input  logic               slower,
  input  logic [1:0]         mode,
  output logic [N_LEDS-1:0]  led,
  output logic [DELAY_W-1:0] delay,
  output logic               step_stb
);

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0]  PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [DELAY_W-1:0] DELAY_MAX = '1;
  localparam logic [N_LEDS-1:0]  LED_ONE   = N_LEDS'(1);

  function automatic logic [N_LEDS-1:0] f_alt_init(input int n);
    logic [N_LEDS-1:0] v;
    v = '0;
    for (int i = 0; i < n; i += 2) v[i] = 1'b1;
    return v;
  endfunction

  localparam logic [N_LEDS-1:0] ALT_INIT = f_alt_init(N_LEDS);

  logic w_pause, w_restart, w_faster, w_slower;

`ifdef LED_SEQ_SYNC_EN
  logic [3:0] r_sync1, r_sync2, r_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync_q <= '0;
    end else begin
      r_sync1  <= {pause, restart, faster, slower};
      r_sync2  <= r_sync1;
      r_sync_q <= r_sync2;
    end
  end

  assign {w_pause, w_restart, w_faster, w_slower} = r_sync2 & ~r_sync_q;
`else
  assign {w_pause, w_restart, w_faster, w_slower} = {pause, restart, faster, slower};
`endif

  // state    | meaning
  // S_RUN    | prescaler and step counter advance, pattern steps
  // S_PAUSED | counters and led hold; delay still adjustable
  typedef enum logic {S_RUN = 1'b0, S_PAUSED = 1'b1} state_t;

  state_t r_state, w_state_nxt;
  logic   w_running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart)    w_state_nxt = S_RUN;
    else if (w_pause) w_state_nxt = (r_state == S_RUN) ? S_PAUSED : S_RUN;
  end

  always_comb begin
    w_running = (r_state == S_RUN);
  end

  logic [PCNT_W-1:0]  r_pcnt;
  logic [DELAY_W-1:0] r_scnt;
  logic [DELAY_W-1:0] r_delay;
  logic               w_tick, w_step;

  assign w_tick = w_running && (r_pcnt == PCNT_LAST);
  // ">=" lets a shortened delay step on the next tick instead of waiting for wrap
  assign w_step = w_tick && (r_scnt >= r_delay) && !w_restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= '0;
      r_scnt <= '0;
    end else if (w_restart) begin
      r_pcnt <= '0;
      r_scnt <= '0;
    end else if (w_running) begin
      if (w_tick) begin
        r_pcnt <= '0;
        r_scnt <= (r_scnt >= r_delay) ? '0 : r_scnt + 1'b1;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_delay <= DELAY_W'(DELAY_INIT);
    else if (w_faster && !w_slower && (r_delay != '0))
      r_delay <= r_delay - 1'b1;
    else if (w_slower && !w_faster && (r_delay != DELAY_MAX))
      r_delay <= r_delay + 1'b1;
  end

  logic [N_LEDS-1:0] r_led, w_init;
  logic [1:0]        r_mode_q;
  logic              r_dir_up;
  logic              r_step_stb;

  always_comb begin
    w_init = LED_ONE;
    case (mode)
      2'd2:    w_init = '0;
      2'd3:    w_init = ALT_INIT;
      default: w_init = LED_ONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led      <= LED_ONE;
      r_mode_q   <= 2'd0;
      r_dir_up   <= 1'b1;
      r_step_stb <= 1'b0;
    end else begin
      r_step_stb <= w_step;
      if (w_restart || (w_step && (mode != r_mode_q))) begin
        r_led    <= w_init;
        r_mode_q <= mode;
        r_dir_up <= 1'b1;
      end else if (w_step) begin
        case (r_mode_q)
          2'd0: r_led <= {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
          2'd1: begin
            if (r_dir_up) begin
              if (r_led[N_LEDS-1]) begin
                r_led    <= r_led >> 1;
                r_dir_up <= 1'b0;
              end else begin
                r_led <= r_led << 1;
              end
            end else begin
              if (r_led[0]) begin
                r_led    <= r_led << 1;
                r_dir_up <= 1'b1;
              end else begin
                r_led <= r_led >> 1;
              end
            end
          end
          2'd2:    r_led <= r_led + 1'b1;
          default: r_led <= ~r_led;
        endcase
      end
    end
  end

  assign led      = r_led;
  assign delay    = r_delay;
  assign step_stb = r_step_stb;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (N_LEDS=4, PRESCALE=4, DELAY_INIT=2): directed scenarios plus
// randomized control pulses checked against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_led_sequencer;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int DI = 2;
  localparam int P  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pause = 1'b0, restart = 1'b0, faster = 1'b0, slower = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [N-1:0]  led;
  logic [DW-1:0] delay;
  logic          step_stb;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  led_sequencer #(.N_LEDS(N), .DELAY_W(DW), .DELAY_INIT(DI), .PRESCALE(P)) dut (
    .clk(clk), .reset_n(reset_n), .pause(pause), .restart(restart),
    .faster(faster), .slower(slower), .mode(mode),
    .led(led), .delay(delay), .step_stb(step_stb)
  );

  // Reference model: m_el counts running cycles since the last step/restart; a tick is
  // every P-th such cycle and a step fires on a tick once el/P ticks have reached delay.
  logic [N-1:0]  m_led, n_led;
  logic [DW-1:0] m_delay, n_delay;
  int            m_mode_q, n_mode_q, m_pos, n_pos, m_el, n_el;
  bit            m_run, n_run, m_up, n_up, m_stb, n_stb;

  function automatic logic [N-1:0] init_pat(input int md);
    case (md)
      2:       return 4'b0000;
      3:       return 4'b0101;
      default: return 4'b0001;
    endcase
  endfunction

  always_comb begin
    n_led = m_led; n_delay = m_delay; n_mode_q = m_mode_q; n_pos = m_pos;
    n_el = m_el; n_run = m_run; n_up = m_up; n_stb = 1'b0;
    if (restart) begin
      n_led = init_pat(int'(mode)); n_mode_q = int'(mode); n_pos = 0; n_up = 1'b1;
      n_el = 0; n_run = 1'b1;
    end else begin
      if (m_run) begin
        if ((m_el % P == P - 1) && (m_el / P >= int'(m_delay))) begin
          n_stb = 1'b1;
          n_el  = 0;
          if (int'(mode) != m_mode_q) begin
            n_led = init_pat(int'(mode)); n_mode_q = int'(mode); n_pos = 0; n_up = 1'b1;
          end else begin
            case (m_mode_q)
              0: n_led = (m_led << 1) | (m_led >> (N - 1));
              1: begin
                if (m_up) begin
                  if (m_pos == N - 1) begin n_pos = m_pos - 1; n_up = 1'b0; end
                  else n_pos = m_pos + 1;
                end else begin
                  if (m_pos == 0) begin n_pos = 1; n_up = 1'b1; end
                  else n_pos = m_pos - 1;
                end
                n_led = 4'b0001 << n_pos;
              end
              2: n_led = m_led + 4'd1;
              default: n_led = m_led ^ 4'b1111;
            endcase
          end
        end else begin
          n_el = m_el + 1;
        end
      end
      if (pause) n_run = !m_run;
    end
    if (faster && !slower && m_delay != 4'd0)       n_delay = m_delay - 4'd1;
    else if (slower && !faster && m_delay != 4'd15) n_delay = m_delay + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_led <= 4'b0001; m_delay <= 4'(DI); m_mode_q <= 0; m_pos <= 0;
      m_el <= 0; m_run <= 1'b1; m_up <= 1'b1; m_stb <= 1'b0;
    end else begin
      m_led <= n_led; m_delay <= n_delay; m_mode_q <= n_mode_q; m_pos <= n_pos;
      m_el <= n_el; m_run <= n_run; m_up <= n_up; m_stb <= n_stb;
    end
  end

  // Waits (bounded) for the next step strobe; cnt = negedges elapsed, 100 on timeout.
  task automatic wait_stb(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (step_stb !== 1'b1 && cnt < 100);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (led !== 4'b0001) $display("FAIL reset_led got %b want 0001", led); else n_pass++;
    n_total++; if (delay !== 4'd2) $display("FAIL reset_delay got %0d want 2", delay); else n_pass++;
    n_total++; if (step_stb !== 1'b0) $display("FAIL reset_stb got %b want 0", step_stb); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_rotate();
    logic [N-1:0] exp_led [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int c;
    for (int k = 0; k < 4; k++) begin
      wait_stb(c);
      n_total++; if (c !== 12) $display("FAIL rotate_gap%0d got %0d want 12", k, c); else n_pass++;
      n_total++; if (led !== exp_led[k]) $display("FAIL rotate_led%0d got %b want %b", k, led, exp_led[k]); else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] exp_led [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    int c;
    mode = 2'd1;
    for (int k = 0; k < 8; k++) begin
      wait_stb(c);
      n_total++; if (c !== 12) $display("FAIL bounce_gap%0d got %0d want 12", k, c); else n_pass++;
      n_total++; if (led !== exp_led[k]) $display("FAIL bounce_led%0d got %b want %b", k, led, exp_led[k]); else n_pass++;
    end
  endtask

  task automatic test_binary();
    int c;
    logic [N-1:0] want;
    mode = 2'd2;
    for (int k = 0; k <= 16; k++) begin
      want = 4'(k % 16);
      wait_stb(c);
      n_total++; if (c !== 12) $display("FAIL binary_gap%0d got %0d want 12", k, c); else n_pass++;
      n_total++; if (led !== want) $display("FAIL binary_led%0d got %b want %b", k, led, want); else n_pass++;
    end
  endtask

  task automatic test_pause();
    int c;
    mode = 2'd0;
    wait_stb(c);
    n_total++; if (led !== 4'b0001) $display("FAIL pause_reload got %b want 0001", led); else n_pass++;
    wait_stb(c);
    n_total++; if (led !== 4'b0010) $display("FAIL pause_step2 got %b want 0010", led); else n_pass++;
    pause = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      pause = 1'b0;
      n_total++;
      if (step_stb !== 1'b0 || led !== 4'b0010)
        $display("FAIL paused_hold%0d stb=%b led=%b want stb=0 led=0010", i, step_stb, led);
      else n_pass++;
    end
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    wait_stb(c);
    c++;
    // one running cycle elapsed before the pause took effect; the resume edge itself is paused
    n_total++; if (c !== 12) $display("FAIL pause_resume_gap got %0d want 12", c); else n_pass++;
    n_total++; if (led !== 4'b0100) $display("FAIL pause_resume_led got %b want 0100", led); else n_pass++;
  endtask

  task automatic test_delay();
    int c;
    faster = 1'b1; repeat (5) @(negedge clk); faster = 1'b0;
    n_total++; if (delay !== 4'd0) $display("FAIL faster_sat got %0d want 0", delay); else n_pass++;
    wait_stb(c);
    for (int k = 0; k < 2; k++) begin
      wait_stb(c);
      n_total++; if (c !== 4) $display("FAIL fast_gap%0d got %0d want 4", k, c); else n_pass++;
    end
    slower = 1'b1; repeat (20) @(negedge clk); slower = 1'b0;
    n_total++; if (delay !== 4'd15) $display("FAIL slower_sat got %0d want 15", delay); else n_pass++;
    faster = 1'b1; repeat (10) @(negedge clk); faster = 1'b0;
    n_total++; if (delay !== 4'd5) $display("FAIL faster_x10 got %0d want 5", delay); else n_pass++;
    faster = 1'b1; slower = 1'b1; repeat (3) @(negedge clk); faster = 1'b0; slower = 1'b0;
    n_total++; if (delay !== 4'd5) $display("FAIL both_same_cycle got %0d want 5", delay); else n_pass++;
  endtask

  task automatic test_midcount();
    int c;
    wait_stb(c);
    repeat (8) @(negedge clk);
    faster = 1'b1; repeat (4) @(negedge clk); faster = 1'b0;
    n_total++; if (step_stb !== 1'b1) $display("FAIL midcount_step got %b want 1", step_stb); else n_pass++;
    n_total++; if (delay !== 4'd1) $display("FAIL midcount_delay got %0d want 1", delay); else n_pass++;
  endtask

  task automatic test_async_reset_restart();
    int c;
    repeat (5) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_total++; if (led !== 4'b0001) $display("FAIL areset_led got %b want 0001", led); else n_pass++;
    n_total++; if (delay !== 4'd2) $display("FAIL areset_delay got %0d want 2", delay); else n_pass++;
    n_total++; if (step_stb !== 1'b0) $display("FAIL areset_stb got %b want 0", step_stb); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    mode = 2'd3;
    repeat (5) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_total++; if (led !== 4'b0101 || step_stb !== 1'b0) $display("FAIL restart_load led=%b stb=%b want 0101/0", led, step_stb); else n_pass++;
    wait_stb(c);
    n_total++; if (c !== 12) $display("FAIL restart_gap got %0d want 12", c); else n_pass++;
    n_total++; if (led !== 4'b1010) $display("FAIL restart_invert got %b want 1010", led); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_total++;
      if (led !== m_led || delay !== m_delay || step_stb !== m_stb)
        $display("FAIL random%0d led=%b/%b delay=%0d/%0d stb=%b/%b (got/want)",
                 i, led, m_led, delay, m_delay, step_stb, m_stb);
      else n_pass++;
      pause   = ($urandom_range(99) < 3);
      restart = ($urandom_range(99) < 1);
      faster  = ($urandom_range(99) < 6);
      slower  = ($urandom_range(99) < 6);
      if ($urandom_range(99) < 2) mode = 2'($urandom_range(3));
    end
    pause = 1'b0; restart = 1'b0; faster = 1'b0; slower = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_binary();
    test_pause();
    test_delay();
    test_midcount();
    test_async_reset_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
